// File: rtl/cp0_regfile.sv
// cp0_regfile: coprocessor-0 register file.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC. Captures exceptions
// and ERET, serves the MTC0/MFC0 port, samples hardware and timer interrupts,
// and raises irq_pending to the exception detector.
// Optional feature: define CP0_TIMER_EN to build the Count/Compare timer.
// Without it, Count/Compare read 0 and TI is tied low.
module cp0_regfile #(
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000,
    parameter int          COUNT_DIV    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cp0_exp_en,
    input  logic        cp0_exl_clean,
    input  logic [31:0] cp0_exp_epc,
    input  logic [4:0]  cp0_exp_code,
    input  logic [31:0] cp0_exp_bad_vaddr,
    input  logic        cp0_exp_bad_vaddr_wen,
    input  logic        cp0_exp_bd,
    input  logic [5:0]  hw_int,
    input  logic        cp0_wen,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic [31:0] epc_address,
    output logic [31:0] status_out,
    output logic [31:0] cause_out,
    output logic        irq_pending
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    logic [31:0] status_q;
    logic [31:0] epc_q;
    logic [31:0] bad_vaddr_q;
    logic        cause_bd_q;
    logic [5:0]  cause_ip_hw_q;
    logic [1:0]  cause_ip_sw_q;
    logic [4:0]  cause_code_q;
    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic        timer_int;
    logic [31:0] cause_val;

    logic wr_status;
    logic wr_cause;
    logic wr_epc;

    assign wr_status = cp0_wen && (cp0_waddr == REG_STATUS);
    assign wr_cause  = cp0_wen && (cp0_waddr == REG_CAUSE);
    assign wr_epc    = cp0_wen && (cp0_waddr == REG_EPC);

    // Status: MTC0 owns IM/IE; EXL is set by exceptions, cleared by ERET, else MTC0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q <= STATUS_RESET;
        end else begin
            if (wr_status) begin
                status_q[15:8] <= cp0_wdata[15:8];
                status_q[0]    <= cp0_wdata[0];
            end
            if (cp0_exp_en) begin
                status_q[1] <= 1'b1;
            end else if (cp0_exl_clean) begin
                status_q[1] <= 1'b0;
            end else if (wr_status) begin
                status_q[1] <= cp0_wdata[1];
            end
        end
    end

    // EPC: first-level exception capture wins over an MTC0 write; nested exceptions keep it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_q <= '0;
        end else if (cp0_exp_en && !status_q[1]) begin
            epc_q <= cp0_exp_epc;
        end else if (wr_epc) begin
            epc_q <= cp0_wdata;
        end
    end

    // Cause: BD/ExcCode from exceptions, soft IP from MTC0, hard IP sampled every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_bd_q    <= 1'b0;
            cause_code_q  <= '0;
            cause_ip_sw_q <= '0;
            cause_ip_hw_q <= '0;
        end else begin
            if (cp0_exp_en && !status_q[1]) begin
                cause_bd_q <= cp0_exp_bd;
            end
            if (cp0_exp_en) begin
                cause_code_q <= cp0_exp_code;
            end
            if (wr_cause) begin
                cause_ip_sw_q <= cp0_wdata[9:8];
            end
            cause_ip_hw_q <= {hw_int[5] | timer_int, hw_int[4:0]};
        end
    end

    // BadVAddr: loaded only by exceptions that report a faulting address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_vaddr_q <= '0;
        end else if (cp0_exp_en && cp0_exp_bad_vaddr_wen) begin
            bad_vaddr_q <= cp0_exp_bad_vaddr;
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        div_q;
    logic        ti_q;
    logic        count_tick;
    logic        wr_count;
    logic        wr_compare;

    assign wr_count   = cp0_wen && (cp0_waddr == REG_COUNT);
    assign wr_compare = cp0_wen && (cp0_waddr == REG_COMPARE);
    assign count_tick = (COUNT_DIV == 1) || div_q;

    // Count: divided free-running counter; an MTC0 write reloads it and restarts the divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            div_q   <= 1'b0;
        end else if (wr_count) begin
            count_q <= cp0_wdata;
            div_q   <= 1'b0;
        end else begin
            div_q <= (COUNT_DIV == 2) ? ~div_q : 1'b0;
            if (count_tick) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // Compare and TI: match sets TI sticky; a Compare write clears it and wins over a match
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else if (wr_compare) begin
            compare_q <= cp0_wdata;
            ti_q      <= 1'b0;
        end else if (count_q == compare_q) begin
            ti_q <= 1'b1;
        end
    end

    assign count_val   = count_q;
    assign compare_val = compare_q;
    assign timer_int   = ti_q;
`else
    logic unused_count_div;

    assign unused_count_div = (COUNT_DIV == 2);
    assign count_val        = '0;
    assign compare_val      = '0;
    assign timer_int        = 1'b0;
`endif

    assign cause_val = {cause_bd_q, 15'b0, cause_ip_hw_q, cause_ip_sw_q, 1'b0, cause_code_q, 2'b0};

    // MFC0 read mux from current register contents; no write bypass
    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            REG_BADVADDR: cp0_rdata = bad_vaddr_q;
            REG_COUNT:    cp0_rdata = count_val;
            REG_COMPARE:  cp0_rdata = compare_val;
            REG_STATUS:   cp0_rdata = status_q;
            REG_CAUSE:    cp0_rdata = cause_val;
            REG_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = '0;
        endcase
    end

    assign epc_address = epc_q;
    assign status_out  = status_q;
    assign cause_out   = cause_val;
    assign irq_pending = status_q[0] & ~status_q[1] & (|(cause_val[15:8] & status_q[15:8]));

endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: self-checking bench for cp0_regfile.
// Directed scenarios plus randomized MTC0/exception/interrupt traffic compared
// against a field-level behavioural model. Timer checks run when CP0_TIMER_EN is defined.
module tb_cp0_regfile;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam int          COUNT_DIV    = 2;

    logic        clk;
    logic        rst;
    logic        cp0_exp_en;
    logic        cp0_exl_clean;
    logic [31:0] cp0_exp_epc;
    logic [4:0]  cp0_exp_code;
    logic [31:0] cp0_exp_bad_vaddr;
    logic        cp0_exp_bad_vaddr_wen;
    logic        cp0_exp_bd;
    logic [5:0]  hw_int;
    logic        cp0_wen;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic [31:0] epc_address;
    logic [31:0] status_out;
    logic [31:0] cause_out;
    logic        irq_pending;

    int checks = 0;
    int errors = 0;

    // Model state, one variable per architectural field
    logic [7:0]  m_im;
    logic        m_exl;
    logic        m_ie;
    logic        m_bd;
    logic [4:0]  m_code;
    logic [1:0]  m_ip_sw;
    logic [5:0]  m_ip_hw;
    logic [31:0] m_epc;
    logic [31:0] m_badv;
    logic [31:0] m_count;
    logic [31:0] m_compare;
    logic        m_ti;
    int          m_phase;

    cp0_regfile #(
        .STATUS_RESET(STATUS_RESET),
        .COUNT_DIV(COUNT_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cp0_exp_en(cp0_exp_en),
        .cp0_exl_clean(cp0_exl_clean),
        .cp0_exp_epc(cp0_exp_epc),
        .cp0_exp_code(cp0_exp_code),
        .cp0_exp_bad_vaddr(cp0_exp_bad_vaddr),
        .cp0_exp_bad_vaddr_wen(cp0_exp_bad_vaddr_wen),
        .cp0_exp_bd(cp0_exp_bd),
        .hw_int(hw_int),
        .cp0_wen(cp0_wen),
        .cp0_waddr(cp0_waddr),
        .cp0_wdata(cp0_wdata),
        .cp0_raddr(cp0_raddr),
        .cp0_rdata(cp0_rdata),
        .epc_address(epc_address),
        .status_out(status_out),
        .cause_out(cause_out),
        .irq_pending(irq_pending)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] modelStatus();
        return {STATUS_RESET[31:16], m_im, STATUS_RESET[7:2], m_exl, m_ie};
    endfunction

    function automatic logic [31:0] modelCause();
        return {m_bd, 15'b0, m_ip_hw, m_ip_sw, 1'b0, m_code, 2'b0};
    endfunction

    function automatic logic modelIrq();
        logic [31:0] c;
        c = modelCause();
        return m_ie && !m_exl && ((c[15:8] & m_im) != 8'h00);
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] addr);
        case (addr)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return modelStatus();
            5'd13:   return modelCause();
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelReset();
        m_im      = STATUS_RESET[15:8];
        m_exl     = STATUS_RESET[1];
        m_ie      = STATUS_RESET[0];
        m_bd      = 1'b0;
        m_code    = '0;
        m_ip_sw   = '0;
        m_ip_hw   = '0;
        m_epc     = '0;
        m_badv    = '0;
        m_count   = '0;
        m_compare = '0;
        m_ti      = 1'b0;
        m_phase   = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic modelStep();
        logic        old_exl;
        logic        old_ti;
        logic [31:0] old_count;
        logic [31:0] old_compare;
        if (rst) begin
            modelReset();
            return;
        end
        old_exl     = m_exl;
        old_ti      = m_ti;
        old_count   = m_count;
        old_compare = m_compare;

        if (cp0_exp_en && !old_exl) m_epc = cp0_exp_epc;
        else if (cp0_wen && cp0_waddr == 5'd14) m_epc = cp0_wdata;

        if (cp0_exp_en && !old_exl) m_bd = cp0_exp_bd;
        if (cp0_exp_en) m_code = cp0_exp_code;
        if (cp0_exp_en && cp0_exp_bad_vaddr_wen) m_badv = cp0_exp_bad_vaddr;

        if (cp0_wen && cp0_waddr == 5'd12) begin
            m_im = cp0_wdata[15:8];
            m_ie = cp0_wdata[0];
        end
        if (cp0_exp_en) m_exl = 1'b1;
        else if (cp0_exl_clean) m_exl = 1'b0;
        else if (cp0_wen && cp0_waddr == 5'd12) m_exl = cp0_wdata[1];

        if (cp0_wen && cp0_waddr == 5'd13) m_ip_sw = cp0_wdata[9:8];
        m_ip_hw = {hw_int[5] | old_ti, hw_int[4:0]};

`ifdef CP0_TIMER_EN
        if (cp0_wen && cp0_waddr == 5'd9) begin
            m_count = cp0_wdata;
            m_phase = 0;
        end else begin
            m_phase = m_phase + 1;
            if (m_phase == COUNT_DIV) begin
                m_count = old_count + 32'd1;
                m_phase = 0;
            end
        end
        if (cp0_wen && cp0_waddr == 5'd11) begin
            m_compare = cp0_wdata;
            m_ti      = 1'b0;
        end else if (old_count == old_compare) begin
            m_ti = 1'b1;
        end
`else
        if (old_count != old_compare) m_ti = 1'b0;
`endif
    endtask

    task automatic setIdle();
        cp0_exp_en            = 1'b0;
        cp0_exl_clean         = 1'b0;
        cp0_exp_epc           = '0;
        cp0_exp_code          = '0;
        cp0_exp_bad_vaddr     = '0;
        cp0_exp_bad_vaddr_wen = 1'b0;
        cp0_exp_bd            = 1'b0;
        hw_int                = '0;
        cp0_wen               = 1'b0;
        cp0_waddr             = '0;
        cp0_wdata             = '0;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    // Compare every observable output with the model, then take one edge
    task automatic runCycle();
        @(negedge clk);
        checkOutput("status", status_out, modelStatus());
        checkOutput("cause", cause_out, modelCause());
        checkOutput("epc", epc_address, m_epc);
        checkOutput("irq", {31'b0, irq_pending}, {31'b0, modelIrq()});
        checkOutput("rdata", cp0_rdata, modelRead(cp0_raddr));
        stepEdge();
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        setIdle();
        cp0_wen   = 1'b1;
        cp0_waddr = addr;
        cp0_wdata = data;
        runCycle();
        setIdle();
    endtask

    function automatic logic [4:0] pickAddr();
        case ($urandom_range(0, 7))
            0:       return 5'd8;
            1:       return 5'd9;
            2:       return 5'd11;
            3:       return 5'd12;
            4:       return 5'd13;
            5:       return 5'd14;
            6:       return 5'd12;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic applyStimulus();
        cp0_exp_en            = ($urandom_range(0, 7) == 0);
        cp0_exl_clean         = ($urandom_range(0, 7) == 0);
        cp0_exp_epc           = $urandom;
        cp0_exp_code          = 5'($urandom_range(0, 31));
        cp0_exp_bad_vaddr     = $urandom;
        cp0_exp_bad_vaddr_wen = 1'($urandom_range(0, 1));
        cp0_exp_bd            = 1'($urandom_range(0, 1));
        hw_int                = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'h00;
        cp0_wen               = 1'($urandom_range(0, 1));
        cp0_waddr             = pickAddr();
        cp0_wdata             = $urandom;
        cp0_raddr             = pickAddr();
    endtask

    task automatic resetCheck(input string tag);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput({tag, "_status"}, status_out, 32'h0040_0000);
        checkOutput({tag, "_cause"}, cause_out, 32'h0);
        checkOutput({tag, "_epc"}, epc_address, 32'h0);
        checkOutput({tag, "_irq"}, {31'b0, irq_pending}, 32'h0);
        cp0_raddr = 5'd8;
        #1;
        checkOutput({tag, "_badvaddr"}, cp0_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        stepEdge();
    endtask

    initial begin
        logic reached;
        rst = 1'b1;
        setIdle();
        cp0_raddr = 5'd12;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        resetCheck("reset0");

        // Move Compare away so the post-reset TI settles and clears
        mtc0(5'd11, 32'hFFFF_FFF0);
        repeat (3) runCycle();

        // Exception capture
        setIdle();
        cp0_exp_en            = 1'b1;
        cp0_exp_epc           = 32'h8000_0104;
        cp0_exp_code          = 5'h04;
        cp0_exp_bad_vaddr     = 32'h0000_1003;
        cp0_exp_bad_vaddr_wen = 1'b1;
        cp0_exp_bd            = 1'b1;
        runCycle();
        setIdle();
        cp0_raddr = 5'd8;
        #1;
        checkOutput("exc_epc", epc_address, 32'h8000_0104);
        checkOutput("exc_cause", cause_out, 32'h8000_0010);
        checkOutput("exc_badvaddr", cp0_rdata, 32'h0000_1003);
        checkOutput("exc_exl", {31'b0, status_out[1]}, 32'h1);

        // Nested exception keeps EPC and BD, updates ExcCode
        cp0_exp_en   = 1'b1;
        cp0_exp_epc  = 32'h9000_0000;
        cp0_exp_code = 5'h0A;
        cp0_exp_bd   = 1'b0;
        runCycle();
        setIdle();
        checkOutput("nest_epc", epc_address, 32'h8000_0104);
        checkOutput("nest_cause", cause_out, 32'h8000_0028);

        // ERET clears EXL only
        cp0_exl_clean = 1'b1;
        runCycle();
        setIdle();
        checkOutput("eret_status", status_out, 32'h0040_0000);
        checkOutput("eret_epc", epc_address, 32'h8000_0104);

        // Exception and MTC0 Status in the same cycle; MFC0 sees the old value
        cp0_exp_en   = 1'b1;
        cp0_exp_epc  = 32'h8000_0200;
        cp0_exp_code = 5'h08;
        cp0_wen      = 1'b1;
        cp0_waddr    = 5'd12;
        cp0_wdata    = 32'h0000_0000;
        cp0_raddr    = 5'd12;
        #1;
        checkOutput("prio_rdata_old", cp0_rdata, 32'h0040_0000);
        runCycle();
        setIdle();
        checkOutput("prio_status", status_out, 32'h0040_0002);
        checkOutput("prio_epc", epc_address, 32'h8000_0200);
        cp0_exl_clean = 1'b1;
        runCycle();
        setIdle();

        // Interrupt masking
        cp0_wen   = 1'b1;
        cp0_waddr = 5'd12;
        cp0_wdata = 32'h0000_0401;
        hw_int    = 6'b000001;
        runCycle();
        cp0_wen = 1'b0;
        #1;
        checkOutput("mask_irq_on", {31'b0, irq_pending}, 32'h1);
        cp0_wen   = 1'b1;
        cp0_wdata = 32'h0000_0403;
        runCycle();
        cp0_wen = 1'b0;
        #1;
        checkOutput("mask_exl", {31'b0, irq_pending}, 32'h0);
        cp0_wen   = 1'b1;
        cp0_wdata = 32'h0000_0401;
        runCycle();
        cp0_wen = 1'b0;
        #1;
        checkOutput("mask_irq_again", {31'b0, irq_pending}, 32'h1);
        cp0_wen   = 1'b1;
        cp0_wdata = 32'h0000_0001;
        runCycle();
        cp0_wen = 1'b0;
        #1;
        checkOutput("mask_im_off", {31'b0, irq_pending}, 32'h0);
        setIdle();

`ifdef CP0_TIMER_EN
        // Timer match, TI, interrupt and clear
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd5);
        cp0_raddr = 5'd9;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            runCycle();
            if (cp0_rdata == 32'd5) reached = 1'b1;
        end
        checkOutput("timer_reach", {31'b0, reached}, 32'h1);
        checkOutput("timer_ti_not_yet", {31'b0, cause_out[15]}, 32'h0);
        runCycle();
        runCycle();
        checkOutput("timer_ti_set", {31'b0, cause_out[15]}, 32'h1);
        mtc0(5'd12, 32'h0000_8001);
        checkOutput("timer_irq", {31'b0, irq_pending}, 32'h1);
        mtc0(5'd11, 32'h0000_0100);
        runCycle();
        checkOutput("timer_irq_clear", {31'b0, irq_pending}, 32'h0);
        mtc0(5'd9, 32'hFFFF_FFFF);
        cp0_raddr = 5'd9;
        #1;
        checkOutput("wrap_hold", cp0_rdata, 32'hFFFF_FFFF);
        runCycle();
        runCycle();
        checkOutput("wrap_zero", cp0_rdata, 32'h0);
`else
        // Timer registers absent: writes ignored, reads zero
        reached = 1'b0;
        mtc0(5'd9, 32'h0000_1234);
        mtc0(5'd11, 32'h0000_0005);
        cp0_raddr = 5'd9;
        #1;
        checkOutput("no_timer_count", cp0_rdata, 32'h0);
        cp0_raddr = 5'd11;
        #1;
        checkOutput("no_timer_compare", cp0_rdata, {31'b0, reached});
`endif

        // Randomized traffic against the model, with a reset in the middle
        for (int i = 0; i < 300; i++) begin
            applyStimulus();
            runCycle();
        end
        setIdle();
        resetCheck("reset_mid");
        for (int i = 0; i < 300; i++) begin
            applyStimulus();
            runCycle();
        end
        setIdle();
        runCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
